// File: rtl/z3_slave_cycle_ctrl.sv
// Zorro III slave-cycle engine: synchronised strobes, fixed-priority target
// channels, MTCR burst beats, bus-error timeout and byte-lane capture.
module z3_slave_cycle_ctrl #(
  parameter int NUM_TARGETS    = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SYNC_STAGES    = 2,
  parameter int BEAT_W         = 4,
  localparam int ID_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                   CLK,
  input  logic                   IORST_n,
  input  logic                   FCS_n,
  input  logic [3:0]             DS_n,
  input  logic                   MTCR_n,
  input  logic                   READ,
  input  logic                   DOE,
  input  logic                   validspace,
  input  logic [NUM_TARGETS-1:0] target_sel,
  input  logic [NUM_TARGETS-1:0] target_ack,
  output logic [NUM_TARGETS-1:0] target_req,
  output logic [ID_W-1:0]        target_id,
  output logic [3:0]             lanes,
  output logic                   dtack,
  output logic                   berr,
  output logic                   busy,
  output logic [BEAT_W-1:0]      beat_count
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_END, S_ERROR} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                          state;
  logic [15:0]                     tmo_cnt;
  logic [SYNC_STAGES-1:0]          fcs_sync;
  logic [SYNC_STAGES-1:0]          mtcr_sync;
  logic [SYNC_STAGES-1:0][3:0]     ds_sync;
  logic                            fcs;
  logic                            mtcr;
  logic [3:0]                      ds;

  function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_TARGETS-1:0] sel);
    lowest_set = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--)
      if (sel[i]) lowest_set = ID_W'(i);
  endfunction

  function automatic logic [NUM_TARGETS-1:0] onehot(input logic [ID_W-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

  function automatic logic [BEAT_W-1:0] sat_inc(input logic [BEAT_W-1:0] cnt);
    sat_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

  // Strobe synchronisers, idle (all ones) out of reset
  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      fcs_sync  <= '1;
      mtcr_sync <= '1;
      ds_sync   <= '1;
    end else begin
      fcs_sync  <= {fcs_sync[SYNC_STAGES-2:0], FCS_n};
      mtcr_sync <= {mtcr_sync[SYNC_STAGES-2:0], MTCR_n};
      ds_sync   <= {ds_sync[SYNC_STAGES-2:0], DS_n};
    end
  end

  assign fcs  = fcs_sync[SYNC_STAGES-1];
  assign mtcr = mtcr_sync[SYNC_STAGES-1];
  assign ds   = ds_sync[SYNC_STAGES-1];
  assign busy = (state != S_IDLE);

  // Cycle state machine; every output is a register
  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      state      <= S_IDLE;
      tmo_cnt    <= '0;
      target_id  <= '0;
      target_req <= '0;
      lanes      <= '0;
      dtack      <= 1'b0;
      berr       <= 1'b0;
      beat_count <= '0;
    end else if (fcs && state != S_IDLE) begin
      state      <= S_IDLE;
      target_req <= '0;
      lanes      <= '0;
      dtack      <= 1'b0;
      berr       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fcs && validspace && (|target_sel)) begin
            state      <= S_START;
            target_id  <= lowest_set(target_sel);
            beat_count <= '0;
            tmo_cnt    <= '0;
          end
        end
        S_START: begin
          if (READ || (DOE && ds != 4'hF)) begin
            state      <= S_DATA;
            lanes      <= READ ? 4'hF : ~ds;
            target_req <= onehot(target_id);
            tmo_cnt    <= '0;
          end
        end
        S_DATA: begin
          // An ack arriving on the terminal count still completes the cycle
          if (target_ack[target_id]) begin
            state      <= S_END;
            target_req <= '0;
            beat_count <= sat_inc(beat_count);
          end else if (tmo_cnt == TMO_LAST) begin
            state      <= S_ERROR;
            target_req <= '0;
            berr       <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_END: begin
          if (!mtcr && ds == 4'hF) begin
            state   <= S_START;
            dtack   <= 1'b0;
            tmo_cnt <= '0;
          end else begin
            dtack <= 1'b1;
          end
        end
        S_ERROR: berr <= 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z3_slave_cycle_ctrl.sv
// Bench for z3_slave_cycle_ctrl: directed and randomised Zorro III slave cycles
// checked against a transaction-level model of priority, lanes and outcome.
module tb_z3_slave_cycle_ctrl;

  localparam int NT   = 4;
  localparam int TMO  = 8;
  localparam int SYNC = 2;

  logic          CLK = 1'b0;
  logic          IORST_n = 1'b0;
  logic          FCS_n = 1'b1;
  logic [3:0]    DS_n = 4'hF;
  logic          MTCR_n = 1'b1;
  logic          READ = 1'b0;
  logic          DOE = 1'b0;
  logic          validspace = 1'b0;
  logic [NT-1:0] target_sel = '0;
  logic [NT-1:0] target_ack = '0;
  logic [NT-1:0] target_req;
  logic [1:0]    target_id;
  logic [3:0]    lanes;
  logic          dtack;
  logic          berr;
  logic          busy;
  logic [3:0]    beat_count;

  int n_cmp  = 0;
  int n_fail = 0;

  z3_slave_cycle_ctrl #(
    .NUM_TARGETS(NT), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC), .BEAT_W(4)
  ) dut (
    .CLK(CLK), .IORST_n(IORST_n), .FCS_n(FCS_n), .DS_n(DS_n), .MTCR_n(MTCR_n),
    .READ(READ), .DOE(DOE), .validspace(validspace), .target_sel(target_sel),
    .target_ack(target_ack), .target_req(target_req), .target_id(target_id),
    .lanes(lanes), .dtack(dtack), .berr(berr), .busy(busy), .beat_count(beat_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: priority is the lowest set address-match flag
  function automatic int ref_id(input logic [NT-1:0] sel);
    for (int i = 0; i < NT; i++)
      if (sel[i]) return i;
    return 0;
  endfunction

  function automatic logic [3:0] ref_lanes(input logic rd, input logic [3:0] dsp);
    return rd ? 4'hF : ~dsp;
  endfunction

  function automatic int ref_beats(input int done);
    return (done > 15) ? 15 : done;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req"}, target_req, 0);
    chk({tag, "_lanes"}, lanes, 0);
    chk({tag, "_dtack"}, dtack, 0);
    chk({tag, "_berr"}, berr, 0);
  endtask

  // One FCS cycle of 'beats' beats; the selected target acks ack_dly DATA
  // cycles after its request appears, while 'noise' pulses other channels.
  task automatic run_txn(input logic [NT-1:0] sel, input logic rd, input logic [3:0] dsp,
                         input int ack_dly, input int beats, input logic [NT-1:0] noise);
    int            id;
    logic [NT-1:0] req_exp;
    int            done;
    bit            found;
    bit            acked;
    int            j;
    id      = ref_id(sel);
    req_exp = NT'(1) << id;
    done    = 0;
    @(negedge CLK);
    validspace = 1'b1; target_sel = sel; READ = rd; DOE = ~rd;
    DS_n = dsp; MTCR_n = 1'b1; FCS_n = 1'b0;
    for (int e = 1; e <= SYNC + 1; e++) begin
      @(negedge CLK);
      chk("start_latency", busy, (e == SYNC + 1));
    end
    chk("target_id", target_id, id);
    for (int b = 0; b < beats; b++) begin
      found = 0;
      for (int w = 0; w < 12 && !found; w++) begin
        if (target_req != 0) found = 1;
        else @(negedge CLK);
      end
      chk("req_seen", found, 1);
      chk("target_req", target_req, req_exp);
      chk("lanes", lanes, ref_lanes(rd, dsp));
      j = 0;
      acked = 0;
      forever begin
        if (j == TMO) begin
          target_ack = '0;
          chk("timeout_berr", berr, 1);
          chk("timeout_req", target_req, 0);
          chk("timeout_dtack", dtack, 0);
          break;
        end
        if (j > 0) chk("req_hold", target_req, req_exp);
        if (j == ack_dly) begin
          target_ack = req_exp | noise;
          acked = 1;
          break;
        end
        target_ack = noise & ~req_exp;
        @(negedge CLK);
        j++;
      end
      if (!acked) begin
        repeat (3) begin
          @(negedge CLK);
          chk("berr_held", berr, 1);
        end
        chk("berr_no_dtack", dtack, 0);
        break;
      end
      done++;
      @(negedge CLK);
      target_ack = '0;
      chk("end_entry_dtack", dtack, 0);
      chk("end_req", target_req, 0);
      @(negedge CLK);
      chk("dtack", dtack, 1);
      chk("ack_no_berr", berr, 0);
      chk("beat_count", beat_count, ref_beats(done));
      if (b < beats - 1) begin
        DS_n = 4'hF; MTCR_n = 1'b0;
        found = 0;
        for (int w = 0; w < 10 && !found; w++) begin
          @(negedge CLK);
          if (!dtack) found = 1;
        end
        chk("burst_dtack_drop", found, 1);
        DS_n = dsp; MTCR_n = 1'b1;
      end
    end
    FCS_n = 1'b1; DS_n = 4'hF; MTCR_n = 1'b1; target_ack = '0;
    validspace = 1'b0; target_sel = '0;
    found = 0;
    for (int w = 0; w < 10 && !found; w++) begin
      @(negedge CLK);
      if (!busy) found = 1;
    end
    chk("idle_return", found, 1);
    check_all_zero("after_fcs");
    chk("final_beats", beat_count, ref_beats(done));
  endtask

  initial begin
    logic [NT-1:0] rsel;
    bit            found;
    // Reset state
    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    chk("reset_beats", beat_count, 0);
    chk("reset_id", target_id, 0);
    IORST_n = 1'b1;
    repeat (3) @(negedge CLK);

    // Directed: single read, priority with foreign ack, write lanes
    run_txn(4'b0100, 1'b1, 4'h0, 3, 1, 4'b0000);
    run_txn(4'b1010, 1'b1, 4'h0, 4, 1, 4'b1000);
    run_txn(4'b0001, 1'b0, 4'b1100, 2, 1, 4'b0000);
    // Timeout with no ack, then ack on the terminal DATA cycle
    run_txn(4'b0010, 1'b1, 4'h0, 99, 1, 4'b1101);
    run_txn(4'b1000, 1'b0, 4'b0110, TMO - 1, 1, 4'b0000);
    // Bursts, including beat counter saturation
    run_txn(4'b0100, 1'b0, 4'b0000, 1, 3, 4'b0000);
    run_txn(4'b0110, 1'b1, 4'b0000, 0, 17, 4'b1001);

    // No start without validspace or without a selected target
    @(negedge CLK);
    FCS_n = 1'b0; validspace = 1'b0; target_sel = 4'b0011;
    repeat (5) @(negedge CLK);
    chk("no_validspace", busy, 0);
    validspace = 1'b1; target_sel = '0;
    repeat (4) @(negedge CLK);
    chk("no_target", busy, 0);
    FCS_n = 1'b1; validspace = 1'b0;
    repeat (4) @(negedge CLK);

    // Reset asserted mid-DATA
    validspace = 1'b1; target_sel = 4'b0001; READ = 1'b1; DOE = 1'b0; FCS_n = 1'b0;
    found = 0;
    for (int w = 0; w < 12 && !found; w++) begin
      @(negedge CLK);
      if (target_req != 0) found = 1;
    end
    chk("rst_setup_req", found, 1);
    #2 IORST_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    chk("async_rst_beats", beat_count, 0);
    FCS_n = 1'b1; validspace = 1'b0; target_sel = '0;
    @(negedge CLK);
    IORST_n = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("post_rst_idle", busy, 0);
    end
    run_txn(4'b0010, 1'b0, 4'b1010, 2, 1, 4'b0000);

    // Randomised cycles
    for (int t = 0; t < 25; t++) begin
      rsel = NT'($urandom_range(1, 15));
      run_txn(rsel, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 14)),
              $urandom_range(0, TMO + 2), $urandom_range(1, 4), NT'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
